// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the fetch queue: default depth, bundle layout and
// the PC-select encoding whose ALU value marks a taken redirect.
package fetch_queue_pkg;

  localparam int FQ_DEPTH = 2;

  // Bundle layout inside one storage word, low to high: halt, instr, pc4, pc.
  localparam int FQ_OFF_HALT  = 0;
  localparam int FQ_OFF_INSTR = 1;

  function automatic int fq_off_pc4(input int xlen);
    return FQ_OFF_INSTR + xlen;
  endfunction

  function automatic int fq_off_pc(input int xlen);
    return FQ_OFF_INSTR + 2 * xlen;
  endfunction

  function automatic int fq_width(input int xlen);
    return 3 * xlen + 1;
  endfunction

  // PCSel encoding; PCSel_ALU means the redirect path is taken (drives flush).
  typedef enum logic {
    PCSel_PC4 = 1'b0,
    PCSel_ALU = 1'b1
  } pcsel_e;

endpackage

// File: rtl/fetch_queue_mem.sv
// Bundle storage: one synchronous write port, one combinational read port.
// The array is intentionally not reset; occupancy is tracked by the control.
module fetch_queue_mem #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 97,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write the incoming bundle into the tail slot.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Head slot is read out combinationally.
  always_comb begin
    rdata = mem[raddr];
  end

endmodule

// File: rtl/fetch_queue.sv
// Fetch-to-decode decoupling queue: in-order FIFO of {pc, pc4, instr, halt}
// bundles with redirect flush and halt locking.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH,
  parameter int XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enq_valid,
  output logic                     enq_ready,
  input  logic [XLEN-1:0]          enq_pc,
  input  logic [XLEN-1:0]          enq_pc4,
  input  logic [XLEN-1:0]          enq_instr,
  input  logic                     enq_halt,
  input  logic                     flush,
  output logic                     deq_valid,
  input  logic                     deq_ready,
  output logic [XLEN-1:0]          deq_pc,
  output logic [XLEN-1:0]          deq_pc4,
  output logic [XLEN-1:0]          deq_instr,
  output logic                     deq_halt,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     halted
);

  localparam int PW      = $clog2(DEPTH);
  localparam int CW      = PW + 1;
  localparam int W       = fq_width(XLEN);
  localparam int OFF_PC4 = fq_off_pc4(XLEN);
  localparam int OFF_PC  = fq_off_pc(XLEN);

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic          halt_lock;
  logic          full;
  logic          enq_fire;
  logic          deq_fire;
  logic [W-1:0]  wdata;
  logic [W-1:0]  rdata;

  // Handshake qualifiers depend only on registered state.
  always_comb begin
    full      = (count == CW'(DEPTH));
    enq_ready = !full && !halt_lock && !halted;
    deq_valid = (count != '0);
    enq_fire  = enq_valid && enq_ready;
    deq_fire  = deq_valid && deq_ready;
  end

  // Pack the incoming bundle into a storage word.
  always_comb begin
    wdata                   = '0;
    wdata[FQ_OFF_HALT]      = enq_halt;
    wdata[FQ_OFF_INSTR +: XLEN] = enq_instr;
    wdata[OFF_PC4 +: XLEN]  = enq_pc4;
    wdata[OFF_PC +: XLEN]   = enq_pc;
  end

  // A flushed enqueue must not land in storage.
  fetch_queue_mem #(
    .DEPTH (DEPTH),
    .WIDTH (W),
    .AW    (PW)
  ) u_mem (
    .clk   (clk),
    .we    (enq_fire && !flush),
    .waddr (tail),
    .wdata (wdata),
    .raddr (head),
    .rdata (rdata)
  );

  // Present the head bundle; an empty queue shows zeros.
  always_comb begin
    deq_pc    = '0;
    deq_pc4   = '0;
    deq_instr = '0;
    deq_halt  = 1'b0;
    if (deq_valid) begin
      deq_pc    = rdata[OFF_PC +: XLEN];
      deq_pc4   = rdata[OFF_PC4 +: XLEN];
      deq_instr = rdata[FQ_OFF_INSTR +: XLEN];
      deq_halt  = rdata[FQ_OFF_HALT];
    end
  end

  // Pointer, occupancy and halt state; flush overrides any handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      halt_lock <= 1'b0;
      halted    <= 1'b0;
    end else if (flush) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      halt_lock <= 1'b0;
    end else begin
      if (enq_fire) tail <= tail + 1'b1;
      if (deq_fire) head <= head + 1'b1;
      if (enq_fire && !deq_fire) count <= count + 1'b1;
      else if (!enq_fire && deq_fire) count <= count - 1'b1;
      if (enq_fire && enq_halt) halt_lock <= 1'b1;
      if (deq_fire && deq_halt) halted <= 1'b1;
    end
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Decoupling queue on the consumer side of the instruction-fetch stage, sitting between IFetch and decode.
- Accepts fetched {pc, pc+4, instr, halt} bundles with a valid/ready handshake. Back-pressure to fetch comes from the ready signal.
- Presents the oldest bundle to decode, discards all entries on a branch/jump redirect, and locks after a halt bundle.

Parameters:
- DEPTH, 2, number of entries; power of two, 2..8.
- XLEN, 32, width of pc, pc4 and instr fields.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- enq_valid  in  1  fetch presents a bundle this cycle.
- enq_ready  out  1  queue accepts the bundle this cycle.
- enq_pc  in  XLEN  PC of the fetched instruction.
- enq_pc4  in  XLEN  PC+4 of the fetched instruction.
- enq_instr  in  XLEN  instruction word.
- enq_halt  in  1  fetch-side halt (includes unaligned PC).
- flush  in  1  redirect taken (PCSel = ALU); discard contents.
- deq_valid  out  1  head entry is valid.
- deq_ready  in  1  decode consumes the head this cycle.
- deq_pc  out  XLEN  head entry PC.
- deq_pc4  out  XLEN  head entry PC+4.
- deq_instr  out  XLEN  head entry instruction word.
- deq_halt  out  1  head entry halt flag.
- count  out  clog2(DEPTH)+1  number of occupied entries.
- halted  out  1  sticky; a halt bundle has been dequeued.

Behaviour:
- Reset (async, rst=1):
  - Head pointer, tail pointer and count = 0.
  - halt_lock = 0, halted = 0.
  - deq_valid = 0, enq_ready = 1.
  - deq_* data = 0. Storage contents need not be cleared.
- Handshakes:
  - Enqueue fires when enq_valid & enq_ready.
  - Dequeue fires when deq_valid & deq_ready.
- enq_ready = !full & !halt_lock & !halted. This is combinational from state only and never depends on enq_valid.
- deq_valid = (count != 0). deq_* show the head entry combinationally from storage; when count = 0 they show 0.
- Latency: a bundle enqueued at edge N is visible on deq_* after edge N; minimum 1-cycle latency. There is no same-cycle bypass.
- Pointers are clog2(DEPTH) bits wide and wrap naturally modulo DEPTH.
- count update rules:
  - Enqueue only: +1.
  - Dequeue only: -1.
  - Both in the same cycle: count unchanged, both pointers advance.
- Full (count = DEPTH): enq_ready = 0, so there is no enqueue and dequeue together at full. Dequeue at full is allowed and frees the slot for the next cycle.
- Empty: deq_valid = 0; deq_ready is ignored.
- Halt handling:
  - halt_lock sets on enqueue of a bundle with enq_halt = 1. No further bundles are accepted.
  - halted sets on dequeue of a head with deq_halt = 1. It stays set until reset; flush does not clear it.
- flush (synchronous, highest priority):
  - Pointers and count go to 0 and halt_lock is cleared.
  - Any enqueue or dequeue in the same cycle is discarded. The in-flight enq bundle is dropped; decode must ignore a dequeue it saw in the flush cycle.
- flush while halted = 1: queue empties, enq_ready stays 0.
- Reset asserted mid-operation: state is immediately at reset values; no partial entries survive.

Decomposition:
- Shared package/defines file gets:
  - the FQ_DEPTH default;
  - the bundle field offsets (pc, pc4, instr, halt) as constants;
  - the PCSel encoding, reusing the existing `PCSel_ALU`.
- One sub-module, fetch_queue_mem:
  - DEPTH x (3*XLEN+1) register array;
  - one synchronous write port, one combinational read port;
  - no reset on the array.
- Pointer, count and halt control stay in fetch_queue.

Test Plan:
- Fill then drain: enqueue pc 0x0 and 0x4 with deq_ready = 0.
  - Required: count = 2, enq_ready = 0.
  - Then deq_ready = 1: deq_pc 0x0 then 0x4, deq_pc4 0x4 then 0x8, count returns to 0.
- Streaming: enq_valid = 1 and deq_ready = 1 every cycle, pc 0x0, 0x4, 0x8, ...
  - Required: count steady at 1, one dequeue per cycle, order preserved across pointer wrap (at least 10 entries).
- Flush with a simultaneous enqueue: queue holds 0x10 and 0x14; flush = 1 while enq_pc = 0x18.
  - Required next cycle: count = 0, deq_valid = 0.
  - Then enqueue target 0x40: deq_pc = 0x40.
- Halt: enqueue pc 0x20 with enq_halt = 1.
  - Required: enq_ready = 0 next cycle.
  - Dequeue it: halted = 1.
  - A later flush leaves halted = 1 and enq_ready = 0.
- Flush before a halted entry is consumed: enqueue a halt bundle (unaligned pc 0x22), then flush.
  - Required: halt_lock cleared, enq_ready = 1, halted = 0.
- Asynchronous reset: assert rst between clock edges with count = 2.
  - Required immediately: count = 0, deq_valid = 0, enq_ready = 1, deq_pc = 0.
